gauss3x3_stream: RTL and testbench
==================================

# gauss3x3_stream

Parametrised streaming 3x3 Gaussian filter core, the successor to the fixed 8-bit kernel stage. It sits between the three-row line buffer and the output pixel stream.
- Upstream delivers one column of three vertically adjacent pixels per beat.
- The block generates its own row/column position and image-edge flags from frame parameters, inserts an end-of-row flush beat, and handles border pixels by zero padding or (optionally) replication.
- Output uses a registered valid/ready handshake with full backpressure.

## Interface
- DATA_W, 8: pixel width in bits.
- IMG_W, 640: pixels per row; must be ≥ 2.
- IMG_H, 480: rows per frame; must be ≥ 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_top / in_mid / in_bot  in  DATA_W each  pixels of rows r-1 / r / r+1 at the current column.
- in_valid  in  1  beat present.
- in_sof  in  1  qualifies beat as column 0, row 0 of a new frame.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- border_mode  in  1  0 = zero pad, 1 = replicate (see Configuration); must be static within a frame.
- out_pixel  out  DATA_W  filtered pixel.
- out_valid  out  1  out_pixel valid.
- out_eol  out  1  pixel is the last of its row.
- out_eof  out  1  pixel is the last of the frame.
- out_ready  in  1  downstream accepts when out_valid && out_ready.

## Operation
- The window holds three columns. Each advance shifts in one new column at the right, from an accepted beat or a flush.
- Counters:
  - col counts 0..IMG_W-1 on accepted beats.
  - row counts 0..IMG_H-1 and increments after each flush.
  - After the flush of row IMG_H-1, row wraps to 0.
  - An accepted beat with in_sof forces col=0, row=0 for that beat, discarding any partial row.
- FSM states:
  - RUN: accepts beats.
  - When col IMG_W-1 is accepted, go to FLUSH.
  - FLUSH: one advance with in_ready=0 and an all-zero column shifted in, then return to RUN.
- Output emission:
  - The beat at col 0 only primes the window; it produces no output.
  - The beat at col c ≥ 1 produces the output for center column c-1.
  - FLUSH produces the output for center column IMG_W-1 with out_eol=1. out_eof=1 also when row == IMG_H-1.
- Edge flags apply to the center pixel:
  - top = (row==0), bot = (row==IMG_H-1).
  - left = (center col==0), right = (center col==IMG_W-1).
  - Rows r-1 / r+1 supplied at top/bot edges are don't-care.
- Masking, rows first then columns:
  - Zero mode: masked taps are 0.
  - Replicate mode: a masked row copies the middle row; a masked column copies the middle column. A corner tap therefore equals the center pixel.
- Arithmetic:
  - sum = Σ w·m with weights 1,2,1 / 2,4,2 / 1,2,1, computed with shifts at width DATA_W+4.
  - out_pixel = (sum + 8) >> 4.
  - No saturation is needed: the result never exceeds 2^DATA_W − 1.

## Timing
- Advance condition: adv = !out_valid || out_ready. Both pipeline stages (window, output register) move only on adv.
- in_ready = adv && state==RUN. It is combinational and forced to 0 while rst is high.
- Latency: a beat accepted at edge E updates the window at E. The corresponding output registers at edge E+1 and is visible after E+1, provided adv holds at E+1.
- Stall (out_valid && !out_ready):
  - out_pixel, out_eol, out_eof, window, counters and FSM all hold.
  - A pending FLUSH waits.
- Throughput: one pixel per cycle, with one bubble per row for the flush.
- Reset values: out_valid=0, out_pixel=0, out_eol=0, out_eof=0, col=0, row=0, FSM=RUN, window all zero, window-valid flag 0.
- Reset mid-frame abandons the frame. The next accepted beat is treated as col 0, row 0.

## Configuration
- GAUSS_REPLICATE_EN defined: border_mode is honored (0 zero pad, 1 replicate).
- GAUSS_REPLICATE_EN undefined: border_mode is ignored, zero padding is always used, and the replicate mux logic is not compiled.

## Test plan
- IMG_W=4, IMG_H=3, constant 100, zero mode:
  - corners → 56, non-corner edges → 75, interior → 100.
  - out_eol on every 4th pixel; out_eof on pixel 12.
- Same image, replicate mode (macro defined): all 12 outputs → 100. With the macro undefined and border_mode=1: same results as zero mode.
- Constant 255, IMG_W=IMG_H=8: interior outputs → 255; no wrap past 8 bits.
- out_ready toggled pseudo-randomly: the output sequence is identical to the no-stall run, no pixel is dropped or duplicated, and in_ready=0 during every stall and flush cycle.
- in_sof asserted mid-row:
  - counters restart.
  - the next outputs carry row-0 edge masking.
  - out_eof appears exactly IMG_W·IMG_H outputs after that beat.
- rst pulsed mid-frame: outputs and counters return to reset values immediately. The first post-reset frame matches the golden model.

Source files
------------

// File: rtl/gauss3x3_stream_if.sv
// Stream bundle for gauss3x3_stream: column beats in, filtered pixels out.
// The core uses the slave modport; the pixel source/sink side uses master.
interface gauss3x3_stream_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_top;
   logic [DATA_W-1:0] in_mid;
   logic [DATA_W-1:0] in_bot;
   logic              in_valid;
   logic              in_sof;
   logic              in_ready;
   logic [DATA_W-1:0] out_pixel;
   logic              out_valid;
   logic              out_eol;
   logic              out_eof;
   logic              out_ready;

   modport master (
      output in_top, in_mid, in_bot, in_valid, in_sof, out_ready,
      input  in_ready, out_pixel, out_valid, out_eol, out_eof
   );

   modport slave (
      input  in_top, in_mid, in_bot, in_valid, in_sof, out_ready,
      output in_ready, out_pixel, out_valid, out_eol, out_eof
   );
endinterface

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian filter with self-generated position/edge flags, end-of-row flush and
// zero-pad borders; define GAUSS_REPLICATE_EN to honour border_mode (1 = replicate borders).
//
// state | meaning
// RUN   | accepting column beats from upstream
// FLUSH | one advance with an all-zero column to emit the last pixel of the row
module gauss3x3_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             border_mode,
   gauss3x3_stream_if.slave bus
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic {RUN, FLUSH} state_t;
   typedef logic [2:0][DATA_W-1:0] column_t;   // [0]=top, [1]=mid, [2]=bot

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   column_t [2:0]     win_q, win_d;            // [0]=left (oldest), [2]=right (newest)
   logic              win_vld_q, win_vld_d;
   logic              top_q, top_d, bot_q, bot_d;
   logic              left_q, left_d, right_q, right_d;
   logic              eol_q, eol_d, eof_q, eof_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
   logic              out_eol_q, out_eol_d;
   logic              out_eof_q, out_eof_d;

   logic              adv;
   logic              accept;
   logic [CW-1:0]     col_eff;
   logic [RW-1:0]     row_eff;
   column_t [2:0]     tap;
   logic [DATA_W+3:0] sum;
   logic [DATA_W-1:0] pix_filt;

   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv && (state_q == RUN) && !rst;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_pixel = out_pixel_q;
   assign bus.out_eol   = out_eol_q;
   assign bus.out_eof   = out_eof_q;

   // Rows are masked first so a replicated corner tap ends up equal to the center pixel.
`ifdef GAUSS_REPLICATE_EN
   always_comb begin
      tap = win_q;
      for (int c = 0; c < 3; c++) begin
         if (top_q) tap[c][0] = border_mode ? win_q[c][1] : '0;
         if (bot_q) tap[c][2] = border_mode ? win_q[c][1] : '0;
      end
      if (left_q)  tap[0] = border_mode ? tap[1] : '0;
      if (right_q) tap[2] = border_mode ? tap[1] : '0;
   end
`else
   logic unused_border_mode;
   assign unused_border_mode = border_mode;

   always_comb begin
      tap = win_q;
      for (int c = 0; c < 3; c++) begin
         if (top_q) tap[c][0] = '0;
         if (bot_q) tap[c][2] = '0;
      end
      if (left_q)  tap[0] = '0;
      if (right_q) tap[2] = '0;
   end
`endif

   function automatic logic [DATA_W+3:0] ext(input logic [DATA_W-1:0] p);
      return {4'b0000, p};
   endfunction

   always_comb begin
      sum = ext(tap[0][0])        + (ext(tap[1][0]) << 1) + ext(tap[2][0])
          + (ext(tap[0][1]) << 1) + (ext(tap[1][1]) << 2) + (ext(tap[2][1]) << 1)
          + ext(tap[0][2])        + (ext(tap[1][2]) << 1) + ext(tap[2][2]);
      pix_filt = DATA_W'((sum + (DATA_W+4)'(8)) >> 4);
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      win_vld_d   = win_vld_q;
      top_d       = top_q;
      bot_d       = bot_q;
      left_d      = left_q;
      right_d     = right_q;
      eol_d       = eol_q;
      eof_d       = eof_q;
      out_valid_d = out_valid_q;
      out_pixel_d = out_pixel_q;
      out_eol_d   = out_eol_q;
      out_eof_d   = out_eof_q;
      col_eff     = bus.in_sof ? '0 : col_q;
      row_eff     = bus.in_sof ? '0 : row_q;

      if (adv) begin
         out_valid_d = win_vld_q;
         out_pixel_d = win_vld_q ? pix_filt : out_pixel_q;
         out_eol_d   = win_vld_q && eol_q;
         out_eof_d   = win_vld_q && eof_q;
         win_vld_d   = 1'b0;

         if (state_q == FLUSH) begin
            win_d     = {column_t'('0), win_q[2], win_q[1]};
            win_vld_d = 1'b1;
            left_d    = 1'b0;
            right_d   = 1'b1;
            eol_d     = 1'b1;
            eof_d     = (row_q == ROW_LAST);
            top_d     = (row_q == '0);
            bot_d     = (row_q == ROW_LAST);
            row_d     = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            state_d   = RUN;
         end else if (accept) begin
            win_d     = {{bus.in_bot, bus.in_mid, bus.in_top}, win_q[2], win_q[1]};
            win_vld_d = (col_eff != '0);
            left_d    = (col_eff == CW'(1));
            right_d   = 1'b0;
            eol_d     = 1'b0;
            eof_d     = 1'b0;
            top_d     = (row_eff == '0);
            bot_d     = (row_eff == ROW_LAST);
            row_d     = row_eff;
            if (col_eff == COL_LAST) begin
               col_d   = '0;
               state_d = FLUSH;
            end else begin
               col_d   = col_eff + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '0;
         win_vld_q   <= 1'b0;
         top_q       <= 1'b0;
         bot_q       <= 1'b0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_eol_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         win_vld_q   <= win_vld_d;
         top_q       <= top_d;
         bot_q       <= bot_d;
         left_q      <= left_d;
         right_q     <= right_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_eol_q   <= out_eol_d;
         out_eof_q   <= out_eof_d;
      end
   end
endmodule

// File: tb/tb_gauss3x3_stream.sv
// Bench for gauss3x3_stream: a 4x3 core and an 8x8 core share one stimulus path, outputs are
// compared against a whole-image convolution model with explicit border handling.
module tb_gauss3x3_stream;
   localparam int DW = 8;
`ifdef GAUSS_REPLICATE_EN
   localparam bit REPL_BUILT = 1'b1;
`else
   localparam bit REPL_BUILT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          sel;      // 0 selects the 4x3 core, 1 the 8x8 core
   logic          bmode;
   logic [DW-1:0] t_top, t_mid, t_bot;
   logic          t_valid, t_sof, t_oready;
   logic          o_in_ready, o_valid, o_eol, o_eof;
   logic [DW-1:0] o_pix;

   gauss3x3_stream_if #(.DATA_W(DW)) ifa ();
   gauss3x3_stream_if #(.DATA_W(DW)) ifb ();

   assign ifa.in_top    = t_top;
   assign ifa.in_mid    = t_mid;
   assign ifa.in_bot    = t_bot;
   assign ifa.in_sof    = t_sof;
   assign ifa.in_valid  = t_valid && !sel;
   assign ifa.out_ready = t_oready || sel;
   assign ifb.in_top    = t_top;
   assign ifb.in_mid    = t_mid;
   assign ifb.in_bot    = t_bot;
   assign ifb.in_sof    = t_sof;
   assign ifb.in_valid  = t_valid && sel;
   assign ifb.out_ready = t_oready || !sel;

   assign o_in_ready = sel ? ifb.in_ready  : ifa.in_ready;
   assign o_valid    = sel ? ifb.out_valid : ifa.out_valid;
   assign o_pix      = sel ? ifb.out_pixel : ifa.out_pixel;
   assign o_eol      = sel ? ifb.out_eol   : ifa.out_eol;
   assign o_eof      = sel ? ifb.out_eof   : ifa.out_eof;

   gauss3x3_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(3)) dut_a (
      .clk(clk), .rst(rst), .border_mode(bmode), .bus(ifa.slave));
   gauss3x3_stream #(.DATA_W(DW), .IMG_W(8), .IMG_H(8)) dut_b (
      .clk(clk), .rst(rst), .border_mode(bmode), .bus(ifb.slave));

   typedef struct packed {
      logic [DW-1:0] pix;
      logic          eol;
      logic          eof;
   } exp_t;

   int   img [8][8];
   exp_t exp_q [$];
   int   cur_w, cur_h;
   int   n_vec = 0;
   int   n_err = 0;

   // Out-of-image taps: zero, or clamped to the nearest in-image row/column when replicating.
   function automatic int fetch(int y, int x, int w, int h, bit repl);
      if (repl) begin
         if (y < 0) y = 0;
         if (y > h - 1) y = h - 1;
         if (x < 0) x = 0;
         if (x > w - 1) x = w - 1;
      end else if (y < 0 || y >= h || x < 0 || x >= w) begin
         return 0;
      end
      return img[y][x];
   endfunction

   function automatic void build_expected(int w, int h, bit repl);
      exp_t e;
      exp_q.delete();
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            int s = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  s += (dy == 0 ? 2 : 1) * (dx == 0 ? 2 : 1) * fetch(y + dy, x + dx, w, h, repl);
            e.pix = DW'((s + 8) / 16);
            e.eol = (x == w - 1);
            e.eof = (x == w - 1) && (y == h - 1);
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic void fill_image(bit rand_img, int val);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            img[y][x] = rand_img ? int'($urandom_range(0, 255)) : val;
   endfunction

   // Entered and left just after a rising edge; the beat is accepted on the edge it waits for.
   task automatic drive_beat(input logic [DW-1:0] tp, input logic [DW-1:0] md,
                             input logic [DW-1:0] bt, input logic sof, output bit ok);
      int cnt = 0;
      t_top = tp; t_mid = md; t_bot = bt; t_sof = sof; t_valid = 1'b1;
      @(negedge clk);
      while (!o_in_ready && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      ok = o_in_ready;
      @(posedge clk); #1;
      t_valid = 1'b0; t_sof = 1'b0;
   endtask

   task automatic drive_frame(input int pre, input bit use_sof);
      bit ok;
      for (int i = 0; i < pre; i++) begin
         drive_beat(DW'($urandom), DW'($urandom), DW'($urandom), 1'b0, ok);
         if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL junk_accept beat %0d: in_ready stayed 0, required 1", i);
         end
      end
      for (int y = 0; y < cur_h; y++) begin
         for (int x = 0; x < cur_w; x++) begin
            drive_beat((y > 0) ? DW'(img[y-1][x]) : DW'($urandom), DW'(img[y][x]),
                       (y < cur_h - 1) ? DW'(img[y+1][x]) : DW'($urandom),
                       use_sof && y == 0 && x == 0, ok);
            if (!ok) begin
               n_vec++; n_err++;
               $display("FAIL beat_accept r%0d c%0d: in_ready stayed 0, required 1", y, x);
            end
            if (x == cur_w - 1) begin
               @(negedge clk);
               n_vec++;
               if (o_in_ready !== 1'b0) begin
                  n_err++;
                  $display("FAIL flush_in_ready row %0d: got %b, required 0", y, o_in_ready);
               end
               @(posedge clk); #1;
            end
         end
      end
   endtask

   task automatic monitor_frame(input int n_discard, input bit stall);
      int total = n_discard + cur_w * cur_h;
      int seen = 0;
      int cyc = 0;
      bit was_stall = 1'b0;
      logic [DW+1:0] held = '0;
      exp_t e;
      while (seen < total && cyc < 4000) begin
         @(posedge clk); #1;
         t_oready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         cyc++;
         if (was_stall) begin
            n_vec++;
            if ({o_valid, o_pix, o_eol, o_eof} !== {1'b1, held}) begin
               n_err++;
               $display("FAIL stall_hold: got v=%b pix=%0d eol=%b eof=%b, required v=1 pix=%0d eol=%b eof=%b",
                        o_valid, o_pix, o_eol, o_eof, held[DW+1:2], held[1], held[0]);
            end
         end
         was_stall = o_valid && !t_oready;
         if (was_stall) begin
            held = {o_pix, o_eol, o_eof};
            n_vec++;
            if (o_in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL stall_in_ready: got %b, required 0", o_in_ready);
            end
         end
         if (o_valid && t_oready) begin
            if (seen >= n_discard) begin
               e = exp_q.pop_front();
               n_vec++;
               if ({o_pix, o_eol, o_eof} !== {e.pix, e.eol, e.eof}) begin
                  n_err++;
                  $display("FAIL pixel[%0d]: got pix=%0d eol=%b eof=%b, required pix=%0d eol=%b eof=%b",
                           seen - n_discard, o_pix, o_eol, o_eof, e.pix, e.eol, e.eof);
               end
            end
            seen++;
         end
      end
      if (seen < total) begin
         n_vec++; n_err++;
         $display("FAIL output_timeout: got %0d outputs, required %0d", seen, total);
      end
      @(posedge clk); #1;
      t_oready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL trailing_output: out_valid got %b, required 0", o_valid);
      end
   endtask

   task automatic run_frame(input int pre, input int n_discard, input bit use_sof, input bit stall);
      build_expected(cur_w, cur_h, bmode && REPL_BUILT);
      @(posedge clk); #1;
      fork
         drive_frame(pre, use_sof);
         monitor_frame(n_discard, stall);
      join
   endtask

   task automatic select_core(input logic s);
      sel = s;
      cur_w = s ? 8 : 4;
      cur_h = s ? 8 : 3;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      n_vec++;
      if ({o_valid, o_pix, o_eol, o_eof, o_in_ready} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b pix=%0d eol=%b eof=%b in_ready=%b, required all 0",
                  o_valid, o_pix, o_eol, o_eof, o_in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_const;
      select_core(1'b0);
      bmode = 1'b0;
      fill_image(1'b0, 100);
      run_frame(0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_replicate_const;
      select_core(1'b0);
      bmode = 1'b1;
      fill_image(1'b0, 100);
      run_frame(0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_const255_8x8;
      select_core(1'b1);
      bmode = 1'b0;
      fill_image(1'b0, 255);
      run_frame(0, 0, 1'b1, 1'b0);
      bmode = 1'b1;
      run_frame(0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_random_stall;
      select_core(1'b0);
      for (int f = 0; f < 4; f++) begin
         bmode = 1'($urandom_range(0, 1));
         fill_image(1'b1, 0);
         run_frame(0, 0, 1'b1, 1'b1);
      end
      select_core(1'b1);
      bmode = 1'($urandom_range(0, 1));
      fill_image(1'b1, 0);
      run_frame(0, 0, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back;
      select_core(1'b0);
      bmode = 1'b0;
      fill_image(1'b1, 0);
      run_frame(0, 0, 1'b0, 1'b0);
      run_frame(0, 0, 1'b0, 1'b0);
   endtask

   // One full row plus two beats of junk, then a frame starting with in_sof mid-row.
   task automatic test_sof_midrow;
      select_core(1'b0);
      bmode = 1'($urandom_range(0, 1));
      fill_image(1'b1, 0);
      run_frame(cur_w + 2, cur_w + 1, 1'b1, 1'b1);
   endtask

   task automatic test_reset_midframe;
      select_core(1'b0);
      bmode = 1'($urandom_range(0, 1));
      t_oready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) begin
         t_valid = 1'b1; t_sof = (i == 0);
         t_top = DW'($urandom); t_mid = DW'($urandom); t_bot = DW'($urandom);
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({o_valid, o_pix, o_eol, o_eof, o_in_ready} !== '0) begin
         n_err++;
         $display("FAIL midframe_reset: got v=%b pix=%0d eol=%b eof=%b in_ready=%b, required all 0",
                  o_valid, o_pix, o_eol, o_eof, o_in_ready);
      end
      t_valid = 1'b0; t_sof = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      fill_image(1'b1, 0);
      run_frame(0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel = 1'b0; bmode = 1'b0;
      t_top = '0; t_mid = '0; t_bot = '0;
      t_valid = 1'b0; t_sof = 1'b0; t_oready = 1'b1;
      cur_w = 4; cur_h = 3;
      test_reset();
      test_zero_const();
      test_replicate_const();
      test_const255_8x8();
      test_random_stall();
      test_back_to_back();
      test_sof_midrow();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
